pixel_writer: RTL and testbench
===============================

Name: pixel_writer

Overview:
- Downstream stage of the core control unit. Accepts one rasterised pixel (x, y, colour) from the line/arc generators while the control unit sits in an output-pixel state.
- Computes the linear frame-buffer address, clips off-screen pixels and performs one Avalon-MM write per pixel, honouring waitrequest.
- Returns a one-cycle data_sent pulse to the control unit.
- Also performs a full-screen clear sweep on request.

Parameters:
- SCREEN_W, 640, pixels per row
- SCREEN_H, 480, rows
- COORD_W, 10, width of x/y coordinates
- COLOR_W, 8, bits per pixel; one pixel per bus word
- ADDR_W, 19, bus address width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H
- BASE_ADDR, 0, frame-buffer base word address

Ports:
- clk  in  1  clock
- nreset  in  1  async active-low reset
- pix_valid  in  1  pixel offered (driven from generator data_ready)
- pix_x  in  COORD_W  pixel column, unsigned
- pix_y  in  COORD_W  pixel row, unsigned
- pix_color  in  COLOR_W  pixel colour
- pix_ready  out  1  pixel accepted this cycle when high with pix_valid
- data_sent  out  1  one-cycle pulse: accepted pixel written or clipped
- clear_req  in  1  pulse: start clear sweep
- clear_color  in  COLOR_W  fill colour, sampled on clear_req acceptance
- clear_done  out  1  one-cycle pulse at end of sweep
- busy  out  1  high in any state but IDLE
- clip_cnt  out  16  saturating count of clipped pixels since reset
- av_address  out  ADDR_W  Avalon word address
- av_writedata  out  COLOR_W  Avalon write data
- av_write  out  1  Avalon write strobe
- av_waitrequest  in  1  Avalon slave stall

Behaviour:
- Reset (nreset low, asynchronous): state IDLE. All outputs 0, including clip_cnt. A bus write in flight is abandoned immediately, av_write dropping without waiting for waitrequest.
- States: IDLE, WRITE, SENT, CLEAR, CLRDONE.
- IDLE:
  - pix_ready = 1 unless clear_req is high; clear_req has priority and the pixel is simply not accepted that cycle.
  - On clear_req: latch clear_color; go to CLEAR with av_address = BASE_ADDR.
  - On pix_valid & pix_ready: register x, y, colour.
  - If x >= SCREEN_W or y >= SCREEN_H: go to SENT without a bus cycle; clip_cnt += 1, saturating at 0xFFFF.
  - Otherwise register av_address = BASE_ADDR + y*SCREEN_W + x, computed at full ADDR_W width with no truncation for legal coordinates, and go to WRITE.
- WRITE:
  - av_write = 1; av_address and av_writedata held stable.
  - While av_waitrequest = 1, stay.
  - When av_waitrequest = 0, the transfer completes this cycle; go to SENT.
- SENT:
  - data_sent = 1 for exactly one cycle; pix_ready = 0; go to IDLE.
- Pixel latency:
  - Unstalled, in-range pixel: accept at cycle N, av_write high at N+1, data_sent at N+2.
  - Clipped pixel: data_sent at N+1.
  - Each cycle of waitrequest adds one cycle.
- Single outstanding pixel: pix_ready = 0 in WRITE, SENT, CLEAR and CLRDONE.
- CLEAR:
  - av_write = 1, av_writedata = latched clear colour.
  - Each cycle with av_waitrequest = 0, av_address increments.
  - The write to BASE_ADDR + SCREEN_W*SCREEN_H - 1 completing moves the block to CLRDONE.
  - clear_req and pix_valid are ignored during the sweep.
- CLRDONE: clear_done = 1 for one cycle; go to IDLE.
- av_write is low in IDLE, SENT and CLRDONE.
- busy = (state != IDLE).
- data_sent is never asserted without a preceding accepted pixel.

Decomposition:
- Shared package gpu_pkg holds:
  - the pixel_writer state enum
  - SCREEN_W/SCREEN_H defaults
  - a pixel_t struct (x, y, color) for reuse by the line/arc generators.
- One natural sub-module: pix_addr_calc, a combinational y*SCREEN_W + x + BASE_ADDR with clip flag, reused later by any read-back path.

Test Plan:
- Pixel (x=10, y=2, colour 0x3C), waitrequest low -> av_write one cycle with av_address 1290 and data 0x3C; data_sent pulses 2 cycles after acceptance.
- Same pixel with waitrequest held high 3 cycles -> address/data stable for 4 write cycles; a single data_sent pulse follows completion.
- Pixel (x=640, y=0), then (x=5, y=480) -> no av_write; data_sent 1 cycle after each acceptance; clip_cnt = 2.
- clear_req with clear_color 0x00 and pix_valid high in the same cycle -> pix_ready 0; 307200 writes at addresses 0..307199, all data 0x00; clear_done pulse; busy high throughout; the pixel is accepted in the first cycle back in IDLE.
- Random waitrequest during clear -> every address is written exactly once, in order, with no gaps.
- nreset asserted mid-WRITE with waitrequest high -> av_write drops immediately, no data_sent, clip_cnt = 0; a new pixel after reset release completes normally.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: pixel_writer state encoding, default screen geometry
// and the pixel record passed between the rasteriser stages.
package gpu_pkg;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;
    localparam int unsigned COORD_W_DEF  = 10;
    localparam int unsigned COLOR_W_DEF  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SENT,
        S_CLEAR,
        S_CLRDONE
    } pw_state_t;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COLOR_W_DEF-1:0] color;
    } pixel_t;

endpackage

// File: rtl/pix_addr_calc.sv
// Combinational frame-buffer address for a pixel (BASE + y*W + x) plus an
// off-screen flag; kept separate so a read-back path can share it.
module pix_addr_calc #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_clip
);

    // Widen before multiplying so legal coordinates never lose high bits.
    always_comb begin
        o_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(i_y) * ADDR_W'(SCREEN_W) + ADDR_W'(i_x);
        o_clip = (32'(i_x) >= SCREEN_W) || (32'(i_y) >= SCREEN_H);
    end

endmodule

// File: rtl/pixel_writer.sv
// Writes rasterised pixels to the frame buffer over Avalon-MM, clipping
// off-screen pixels, and performs full-screen clear sweeps on request.
module pixel_writer
    import gpu_pkg::*;
#(
    parameter int unsigned SCREEN_W  = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H  = SCREEN_H_DEF,
    parameter int unsigned COORD_W   = COORD_W_DEF,
    parameter int unsigned COLOR_W   = COLOR_W_DEF,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic [COLOR_W-1:0] pix_color,
    output logic               pix_ready,
    output logic               data_sent,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_done,
    output logic               busy,
    output logic [15:0]        clip_cnt,
    output logic [ADDR_W-1:0]  av_address,
    output logic [COLOR_W-1:0] av_writedata,
    output logic               av_write,
    input  logic               av_waitrequest
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + SCREEN_W * SCREEN_H - 1);

    pw_state_t         r_state;
    pw_state_t         w_next;
    logic [ADDR_W-1:0] w_pixAddr;
    logic              w_clip;

    pix_addr_calc #(
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H),
        .COORD_W   (COORD_W),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr (
        .i_x    (pix_x),
        .i_y    (pix_y),
        .o_addr (w_pixAddr),
        .o_clip (w_clip)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Strobes are decoded from state so reset drops av_write without waiting on the bus.
    always_comb begin
        w_next     = r_state;
        pix_ready  = 1'b0;
        av_write   = 1'b0;
        data_sent  = 1'b0;
        clear_done = 1'b0;
        busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                pix_ready = nreset && !clear_req;
                if (clear_req) begin
                    w_next = S_CLEAR;
                end else if (pix_valid) begin
                    w_next = w_clip ? S_SENT : S_WRITE;
                end
            end
            S_WRITE: begin
                av_write = 1'b1;
                if (!av_waitrequest) begin
                    w_next = S_SENT;
                end
            end
            S_SENT: begin
                data_sent = 1'b1;
                w_next    = S_IDLE;
            end
            S_CLEAR: begin
                av_write = 1'b1;
                if (!av_waitrequest && av_address == LAST_ADDR) begin
                    w_next = S_CLRDONE;
                end
            end
            S_CLRDONE: begin
                clear_done = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bus address/data and the clip counter; clear colour lives directly in av_writedata.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            av_address   <= '0;
            av_writedata <= '0;
            clip_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_req) begin
                        av_address   <= FIRST_ADDR;
                        av_writedata <= clear_color;
                    end else if (pix_valid) begin
                        if (w_clip) begin
                            if (clip_cnt != 16'hFFFF) begin
                                clip_cnt <= clip_cnt + 16'd1;
                            end
                        end else begin
                            av_address   <= w_pixAddr;
                            av_writedata <= pix_color;
                        end
                    end
                end
                S_CLEAR: begin
                    if (!av_waitrequest) begin
                        av_address <= av_address + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed latency/clip/clear/reset cases
// and random pixel traffic with random waitrequest against a behavioural model.
module tb_pixel_writer;

    localparam int W    = 640;
    localparam int H    = 6;
    localparam int CW   = 10;
    localparam int COLW = 8;
    localparam int AW   = 19;
    localparam int BASE = 0;
    localparam int NPIX = W * H;

    logic            clk = 1'b0;
    logic            nreset;
    logic            pix_valid;
    logic [CW-1:0]   pix_x;
    logic [CW-1:0]   pix_y;
    logic [COLW-1:0] pix_color;
    logic            pix_ready;
    logic            data_sent;
    logic            clear_req;
    logic [COLW-1:0] clear_color;
    logic            clear_done;
    logic            busy;
    logic [15:0]     clip_cnt;
    logic [AW-1:0]   av_address;
    logic [COLW-1:0] av_writedata;
    logic            av_write;
    logic            waitrequest = 1'b0;

    bit randWait  = 1'b0;
    bit forceWait = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    pixel_writer #(
        .SCREEN_W (W), .SCREEN_H (H), .COORD_W (CW), .COLOR_W (COLW),
        .ADDR_W (AW), .BASE_ADDR (BASE)
    ) dut (
        .clk (clk), .nreset (nreset),
        .pix_valid (pix_valid), .pix_x (pix_x), .pix_y (pix_y), .pix_color (pix_color),
        .pix_ready (pix_ready), .data_sent (data_sent),
        .clear_req (clear_req), .clear_color (clear_color), .clear_done (clear_done),
        .busy (busy), .clip_cnt (clip_cnt),
        .av_address (av_address), .av_writedata (av_writedata), .av_write (av_write),
        .av_waitrequest (waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        waitrequest = randWait ? ($urandom_range(0, 2) == 0) : forceWait;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer a pixel until accepted; returns one step after the accepting edge.
    task automatic applyStimulus(input int x, input int y, input int c);
        bit done;
        done      = 1'b0;
        pix_x     = CW'(x);
        pix_y     = CW'(y);
        pix_color = COLW'(c);
        pix_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (pix_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 0, 1);
    endtask

    // Run a clear sweep with a pixel offered alongside; counts completed bus writes.
    task automatic runClear(input int color);
        int  writes;
        bit  seenDone;
        writes      = 0;
        seenDone    = 1'b0;
        clear_color = COLW'(color);
        clear_req   = 1'b1;
        pix_x       = CW'(3);
        pix_y       = CW'(1);
        pix_color   = 8'h77;
        pix_valid   = 1'b1;
        @(negedge clk);
        checkOutput("readyDuringClearReq", pix_ready, 0);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        for (int i = 0; i < 20000 && !seenDone; i++) begin
            @(negedge clk);
            if (av_write && !waitrequest) writes++;
            if (clear_done) seenDone = 1'b1;
        end
        if (!seenDone) checkOutput("clearDoneTimeout", 0, 1);
        checkOutput("clearWriteCount", writes, NPIX);
        @(negedge clk);
        checkOutput("readyAfterClear", pix_ready, 1);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        checkOutput("postClearWrite", av_write, 1);
        checkOutput("postClearAddr", av_address, 643);
        while (!data_sent && busy) cycle();
    endtask

    // Behavioural model: tracks the outstanding job and checks every cycle.
    int phase = 0;
    int pAddr = 0, pColor = 0, clrIdx = 0, clrColor = 0, clips = 0;

    always @(negedge clk) begin
        if (!nreset) begin
            checkOutput("rstPixReady", pix_ready, 0);
            checkOutput("rstAvWrite", av_write, 0);
            checkOutput("rstDataSent", data_sent, 0);
            checkOutput("rstClearDone", clear_done, 0);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstClipCnt", clip_cnt, 0);
            checkOutput("rstAddr", av_address, 0);
            checkOutput("rstData", av_writedata, 0);
            phase = 0;
            clips = 0;
        end else begin
            checkOutput("pixReady", pix_ready, (phase == 0 && !clear_req));
            checkOutput("avWrite", av_write, (phase == 1 || phase == 3));
            checkOutput("dataSent", data_sent, (phase == 2));
            checkOutput("clearDone", clear_done, (phase == 4));
            checkOutput("busy", busy, (phase != 0));
            checkOutput("clipCnt", clip_cnt, clips);
            if (phase == 1) begin
                checkOutput("pixAddr", av_address, pAddr);
                checkOutput("pixData", av_writedata, pColor);
            end
            if (phase == 3) begin
                checkOutput("clrAddr", av_address, BASE + clrIdx);
                checkOutput("clrData", av_writedata, clrColor);
            end
            case (phase)
                0: begin
                    if (clear_req) begin
                        phase    = 3;
                        clrIdx   = 0;
                        clrColor = int'(clear_color);
                    end else if (pix_valid) begin
                        if (int'(pix_x) >= W || int'(pix_y) >= H) begin
                            if (clips < 65535) clips++;
                            phase = 2;
                        end else begin
                            pAddr  = BASE + int'(pix_y) * W + int'(pix_x);
                            pColor = int'(pix_color);
                            phase  = 1;
                        end
                    end
                end
                1: if (!waitrequest) phase = 2;
                2: phase = 0;
                3: begin
                    if (!waitrequest) begin
                        if (clrIdx == NPIX - 1) phase = 4;
                        else clrIdx++;
                    end
                end
                default: phase = 0;
            endcase
        end
    end

    initial begin
        nreset      = 1'b0;
        pix_valid   = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_color   = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        repeat (3) cycle();
        nreset = 1'b1;
        cycle();

        // Unstalled pixel: write at N+1, data_sent at N+2.
        applyStimulus(10, 2, 8'h3C);
        checkOutput("p1Write", av_write, 1);
        checkOutput("p1Addr", av_address, 1290);
        checkOutput("p1Data", av_writedata, 8'h3C);
        cycle();
        checkOutput("p1Sent", data_sent, 1);
        cycle();

        // Three stall cycles: four write cycles, then a single data_sent.
        forceWait = 1'b1;
        applyStimulus(10, 2, 8'h3C);
        cycle();
        cycle();
        cycle();
        checkOutput("p2HoldWrite", av_write, 1);
        checkOutput("p2HoldAddr", av_address, 1290);
        checkOutput("p2HoldData", av_writedata, 8'h3C);
        forceWait = 1'b0;
        cycle();
        checkOutput("p2Sent", data_sent, 1);
        cycle();
        checkOutput("p2SentOnce", data_sent, 0);

        // Clipping on both axes and the last legal pixel.
        applyStimulus(640, 0, 8'h11);
        checkOutput("clipXSent", data_sent, 1);
        cycle();
        applyStimulus(5, 480, 8'h22);
        checkOutput("clipYSent", data_sent, 1);
        cycle();
        checkOutput("clipCount2", clip_cnt, 2);
        applyStimulus(639, 5, 8'h33);
        checkOutput("edgeAddr", av_address, 3839);
        cycle();
        applyStimulus(0, 6, 8'h44);
        cycle();
        checkOutput("clipCount3", clip_cnt, 3);

        // Clear sweeps: first unstalled, then with random waitrequest.
        runClear(8'h00);
        cycle();
        randWait = 1'b1;
        runClear(8'hA5);
        cycle();

        // Random traffic including off-screen coordinates.
        repeat (300) begin
            applyStimulus(int'($urandom_range(0, 700)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) cycle();
        end
        while (busy) cycle();

        // Reset in the middle of a stalled write.
        randWait  = 1'b0;
        forceWait = 1'b1;
        repeat (2) cycle();
        applyStimulus(20, 3, 8'h11);
        checkOutput("preRstWrite", av_write, 1);
        #2;
        nreset = 1'b0;
        #1;
        checkOutput("rstDropWrite", av_write, 0);
        checkOutput("rstNoSent", data_sent, 0);
        checkOutput("rstClipZero", clip_cnt, 0);
        cycle();
        nreset    = 1'b1;
        forceWait = 1'b0;
        cycle();
        applyStimulus(20, 3, 8'h5A);
        checkOutput("postRstAddr", av_address, 1940);
        checkOutput("postRstData", av_writedata, 8'h5A);
        cycle();
        checkOutput("postRstSent", data_sent, 1);
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
